// File: rtl/bitmask_popcount_enumerator_pkg.sv
// Shared definitions for the same-popcount bitmask enumerator.
// FSM state encoding used by the top-level controller.
package bitmask_popcount_enumerator_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } state_e;

endpackage

// File: rtl/bitmask_popcount_next_step.sv
// Combinational successor: next larger word with the same popcount.
// carry_o marks the largest word (ones packed at the MSB end).
module bitmask_popcount_next_step
  import bitmask_popcount_enumerator_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] next_o,
  output logic         carry_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] lsb;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic [W-1:0] fill;
  int           h;
  int           sh;

  assign lsb     = x_i & (~x_i + ONE);
  assign sum     = {1'b0, x_i} + {1'b0, lsb};
  assign diff    = x_i ^ sum[W-1:0];
  assign carry_o = sum[W];

  // x = 0 gives h = 0; clamp so the shift never goes negative.
  always_comb begin
    h    = 0;
    sh   = 0;
    fill = '0;
    for (int i = 0; i < W; i++) begin
      h = h + int'(diff[i]);
    end
    if (carry_o) begin
      sh = h;
    end else if (h >= 2) begin
      sh = h - 2;
    end
    if (sh >= W) begin
      fill = '1;
    end else begin
      fill = (ONE << sh) - ONE;
    end
  end

  assign next_o = sum[W-1:0] | fill;

endmodule

// File: rtl/bitmask_popcount_enumerator.sv
// Streams every word with the seed's popcount in ascending order,
// optionally wrapping to the smallest such word.
module bitmask_popcount_enumerator
  import bitmask_popcount_enumerator_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  input  logic [WORD_WIDTH-1:0]  seed_word,
  input  logic                   wrap_enable,
  input  logic                   abort,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [WORD_WIDTH-1:0]  word_out,
  output logic                   word_last,
  output logic [COUNT_WIDTH-1:0] word_index,
  output logic [WORD_WIDTH-1:0]  popcount
);

  localparam logic [WORD_WIDTH-1:0] ONE_W =
    {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] ONE_C =
    {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WORD_WIDTH-1:0] pc_of(
    input logic [WORD_WIDTH-1:0] v
  );
    logic [WORD_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      c = c + {{(WORD_WIDTH-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0]  pc_q, pc_d;
  logic                   wrap_q, wrap_d;

  logic [WORD_WIDTH-1:0]  nxt;
  logic                   carry;
  logic                   is_last;
  logic [WORD_WIDTH-1:0]  wrap_val;

  bitmask_popcount_next_step #(
    .W (WORD_WIDTH)
  ) u_step (
    .x_i     (word_q),
    .next_o  (nxt),
    .carry_o (carry)
  );

  // A zero word has no successor; treat it as its own last word.
  assign is_last  = carry | (word_q == '0);
  assign wrap_val = (pc_q >= WORD_WIDTH[WORD_WIDTH-1:0] + ONE_W - ONE_W)
                  ? '1 : (ONE_W << pc_q) - ONE_W;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (seed_valid) begin
          state_d = RUN;
          word_d  = seed_word;
          idx_d   = '0;
          pc_d    = pc_of(seed_word);
          wrap_d  = wrap_enable;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (word_ready) begin
          if (idx_q != '1) begin
            idx_d = idx_q + ONE_C;
          end
          if (!is_last) begin
            word_d = nxt;
          end else if (wrap_q) begin
            word_d = wrap_val;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign seed_ready = (state_q == IDLE);
  assign word_valid = (state_q == RUN);
  assign word_out   = word_q;
  assign word_last  = word_valid & is_last & ~wrap_q;
  assign word_index = idx_q;
  assign popcount   = pc_q;

endmodule

// File: tb/tb_bitmask_popcount_enumerator.sv
// Directed bench for the enumerator: a 4-bit instance with a 3-bit
// index (to reach saturation) and a default 8-bit instance.
module tb_bitmask_popcount_enumerator;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic       a_sv, a_sr, a_wrap, a_abort, a_wv, a_wr, a_last;
  logic [3:0] a_seed, a_out, a_pop;
  logic [2:0] a_idx;

  logic        b_sv, b_sr, b_wrap, b_abort, b_wv, b_wr, b_last;
  logic [7:0]  b_seed, b_out, b_pop;
  logic [15:0] b_idx;

  bitmask_popcount_enumerator #(
    .WORD_WIDTH  (4),
    .COUNT_WIDTH (3)
  ) u4 (
    .clock       (clk),
    .clear       (clr),
    .seed_valid  (a_sv),
    .seed_ready  (a_sr),
    .seed_word   (a_seed),
    .wrap_enable (a_wrap),
    .abort       (a_abort),
    .word_valid  (a_wv),
    .word_ready  (a_wr),
    .word_out    (a_out),
    .word_last   (a_last),
    .word_index  (a_idx),
    .popcount    (a_pop)
  );

  bitmask_popcount_enumerator u8 (
    .clock       (clk),
    .clear       (clr),
    .seed_valid  (b_sv),
    .seed_ready  (b_sr),
    .seed_word   (b_seed),
    .wrap_enable (b_wrap),
    .abort       (b_abort),
    .word_valid  (b_wv),
    .word_ready  (b_wr),
    .word_out    (b_out),
    .word_last   (b_last),
    .word_index  (b_idx),
    .popcount    (b_pop)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [3:0] s, input logic w);
    a_seed = s;
    a_wrap = w;
    a_sv   = 1'b1;
    step();
    a_sv   = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] s, input logic w);
    b_seed = s;
    b_wrap = w;
    b_sv   = 1'b1;
    step();
    b_sv   = 1'b0;
  endtask

  logic [3:0] seq1 [6]  = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
  logic [3:0] seq2 [10] = '{4'h6, 4'h9, 4'hA, 4'hC, 4'h3,
                            4'h5, 4'h6, 4'h9, 4'hA, 4'hC};

  initial begin
    int k;
    clr = 1'b1;
    {a_sv, a_wrap, a_abort, a_wr} = '0;
    {b_sv, b_wrap, b_abort, b_wr} = '0;
    a_seed = '0;
    b_seed = '0;
    step();
    step();
    clr = 1'b0;

    chk("rst_sr", a_sr, 1);
    chk("rst_wv", a_wv, 0);
    chk("rst_out", a_out, 0);
    chk("rst_last", a_last, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_pop", a_pop, 0);
    chk("rst8_sr", b_sr, 1);
    chk("rst8_idx", b_idx, 0);

    // plain enumeration, ready always high
    a_wr = 1'b1;
    load_a(4'h3, 1'b0);
    chk("t1_pop", a_pop, 2);
    chk("t1_sr", a_sr, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t1_v", a_wv, 1);
      chk("t1_w", a_out, seq1[i]);
      chk("t1_i", a_idx, i);
      chk("t1_l", a_last, (i == 5) ? 1 : 0);
      step();
    end
    chk("t1_drain_v", a_wv, 0);
    chk("t1_drain_sr", a_sr, 0);
    step();
    chk("t1_idle_sr", a_sr, 1);
    chk("t1_idle_v", a_wv, 0);

    // wrap mode, index saturates at 7
    load_a(4'h6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_w", a_out, seq2[i]);
      chk("t2_l", a_last, 0);
      chk("t2_i", a_idx, (i > 7) ? 7 : i);
      step();
    end
    chk("t2_wrapped", a_out, 4'h3);
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    chk("t2_abort_v", a_wv, 0);
    chk("t2_abort_sr", a_sr, 1);

    // ready pattern 1,0,0,1
    a_wr = 1'b0;
    load_a(4'h3, 1'b0);
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      a_wr = ((c % 4) == 0) || ((c % 4) == 3);
      chk("t3_v", a_wv, 1);
      chk("t3_w", a_out, seq1[k]);
      chk("t3_i", a_idx, k);
      step();
      if (a_wr) k++;
    end
    chk("t3_words", k, 6);
    chk("t3_drain_v", a_wv, 0);
    step();
    chk("t3_idle_sr", a_sr, 1);

    // clear mid-stream at index 3
    a_wr = 1'b1;
    load_a(4'h3, 1'b0);
    step();
    step();
    step();
    chk("t4_pre_i", a_idx, 3);
    chk("t4_pre_w", a_out, 4'h9);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_v", a_wv, 0);
    chk("t4_i", a_idx, 0);
    chk("t4_sr", a_sr, 1);
    chk("t4_out", a_out, 0);

    // abort beats accept
    load_a(4'h3, 1'b0);
    step();
    chk("t5_pre_i", a_idx, 1);
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    chk("t5_v", a_wv, 0);
    chk("t5_i", a_idx, 1);
    chk("t5_w", a_out, 4'h5);
    chk("t5_sr", a_sr, 1);
    load_a(4'h5, 1'b0);
    chk("t5_new_w", a_out, 4'h5);
    chk("t5_new_i", a_idx, 0);
    step();
    chk("t5_next_w", a_out, 4'h6);
    chk("t5_next_i", a_idx, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // 8-bit boundaries
    b_wr = 1'b1;
    load_b(8'h00, 1'b0);
    chk("z_v", b_wv, 1);
    chk("z_w", b_out, 0);
    chk("z_l", b_last, 1);
    chk("z_pop", b_pop, 0);
    step();
    chk("z_drain", b_wv, 0);
    step();
    load_b(8'hFF, 1'b0);
    chk("ff_w", b_out, 8'hFF);
    chk("ff_l", b_last, 1);
    chk("ff_pop", b_pop, 8);
    step();
    chk("ff_drain", b_wv, 0);
    step();
    load_b(8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ffw_w", b_out, 8'hFF);
      chk("ffw_l", b_last, 0);
      chk("ffw_i", b_idx, i);
      step();
    end
    b_abort = 1'b1;
    step();
    b_abort = 1'b0;
    load_b(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("zw_w", b_out, 0);
      chk("zw_v", b_wv, 1);
      step();
    end
    b_abort = 1'b1;
    step();
    b_abort = 1'b0;
    load_b(8'h12, 1'b0);
    chk("nm_w0", b_out, 8'h12);
    chk("nm_pop", b_pop, 2);
    step();
    chk("nm_w1", b_out, 8'h14);
    step();
    chk("nm_w2", b_out, 8'h18);
    chk("nm_i2", b_idx, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
